add_sub_pipe: RTL and testbench

- Parametrised, two-stage pipelined signed/unsigned adder-subtractor with an accumulator register; successor to the 4-bit combinational ADD_SUB.
- Carry chain split at WIDTH/2 across two register stages; valid/ready handshake on input and output.
- Used wherever datapath arithmetic must meet timing at wider widths, or where running sums or differences are required.

---
 rtl/add_sub_pkg.sv | 15 +
 rtl/add_sub_slice.sv | 25 ++
 rtl/add_sub_pipe.sv | 163 ++++++++++++++++
 tb/tb_add_sub_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the pipelined adder-subtractor: operation encodings
// and the carry/borrow flag convention.
package add_sub_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    // Subtraction is X + ~Y + 1, so the adder's carry-out is the inverse of the borrow.
    function automatic logic carry_to_flag(input logic is_sub, input logic carry);
        return is_sub ? ~carry : carry;
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// Combinational N-bit adder slice with carry-in; also exposes the carry into
// its MSB so the caller can derive signed overflow.
module add_sub_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0]   full;
    logic [N-1:0] low;

    assign full  = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
    // Sum of the bits below the MSB; its top bit is the carry into the MSB.
    assign low   = {1'b0, x[N-2:0]} + {1'b0, y[N-2:0]} + {{(N-1){1'b0}}, cin};

    assign sum   = full[N-1:0];
    assign cout  = full[N];
    assign c_msb = low[N-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Two-stage pipelined adder-subtractor with accumulator and valid/ready handshakes.
// Optional saturation of overflowing results is enabled by defining ADD_SUB_PIPE_SAT_EN.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    input  logic             ACC_CLR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ANS,
    output logic             CY_BR_OUT,
    output logic             OVF,
    output logic [WIDTH-1:0] ACC
);

    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    logic [WIDTH-1:0] acc_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] ans_reg;
    logic             cy_br_reg;
    logic             ovf_reg;

    logic             s1_valid_reg;
    logic [LO-1:0]    s1_sum_lo_reg;
    logic             s1_carry_reg;
    logic [HI-1:0]    s1_x_hi_reg;
    logic [HI-1:0]    s1_y_hi_reg;
    logic             s1_sub_reg;

    // ---------------- stage 1: operand select and low slice ----------------
    logic             is_acc;
    logic             is_sub;
    logic [WIDTH-1:0] x_op;
    logic [WIDTH-1:0] y_raw;
    logic [WIDTH-1:0] y_op;
    logic [LO-1:0]    lo_sum;
    logic             lo_cout;
    logic             lo_c_msb_unused;

    assign is_acc = (OP == OP_ACC_ADD) || (OP == OP_ACC_SUB);
    assign is_sub = (OP == OP_SUB) || (OP == OP_ACC_SUB);
    assign x_op   = is_acc ? acc_reg : A;
    assign y_raw  = is_acc ? A : B;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_y_inv
            assign y_op[gi] = y_raw[gi] ^ is_sub;
        end
    endgenerate

    add_sub_slice #(.N(LO)) u_slice_lo (
        .x     (x_op[LO-1:0]),
        .y     (y_op[LO-1:0]),
        .cin   (is_sub),
        .sum   (lo_sum),
        .cout  (lo_cout),
        .c_msb (lo_c_msb_unused)
    );

    // ---------------- stage 2: high slice, flags, optional saturation ----------------
    logic [HI-1:0]    hi_sum;
    logic             hi_cout;
    logic             hi_c_msb;
    logic [WIDTH-1:0] res_raw;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;
    logic             cy_br_next;

    add_sub_slice #(.N(HI)) u_slice_hi (
        .x     (s1_x_hi_reg),
        .y     (s1_y_hi_reg),
        .cin   (s1_carry_reg),
        .sum   (hi_sum),
        .cout  (hi_cout),
        .c_msb (hi_c_msb)
    );

    assign res_raw    = {hi_sum, s1_sum_lo_reg};
    assign ovf_next   = hi_c_msb ^ hi_cout;
    assign cy_br_next = carry_to_flag(s1_sub_reg, hi_cout);

`ifdef ADD_SUB_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    // A wrapped result with MSB set came from a positive overflow, and vice versa.
    assign res_next = ovf_next ? (res_raw[WIDTH-1] ? SAT_MAX : SAT_MIN) : res_raw;
`else
    assign res_next = res_raw;
`endif

    // ---------------- handshake ----------------
    logic s2_ready;
    logic s1_adv;
    logic hazard;
    logic in_fire;

    assign s2_ready = !out_valid_reg || OUT_READY;
    assign s1_adv   = s1_valid_reg && s2_ready;
    // ACC is only written when an op leaves S1, so an ACC op must wait for S1 to empty.
    assign hazard   = is_acc && s1_valid_reg;
    assign IN_READY = !RST && (!s1_valid_reg || s1_adv) && !hazard;
    assign in_fire  = IN_VALID && IN_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_reg  <= 1'b0;
            s1_sum_lo_reg <= '0;
            s1_carry_reg  <= 1'b0;
            s1_x_hi_reg   <= '0;
            s1_y_hi_reg   <= '0;
            s1_sub_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            ans_reg       <= '0;
            cy_br_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            acc_reg       <= '0;
        end else begin
            if (!s1_valid_reg || s1_adv) begin
                s1_valid_reg <= in_fire;
                if (in_fire) begin
                    s1_sum_lo_reg <= lo_sum;
                    s1_carry_reg  <= lo_cout;
                    s1_x_hi_reg   <= x_op[WIDTH-1:LO];
                    s1_y_hi_reg   <= y_op[WIDTH-1:LO];
                    s1_sub_reg    <= is_sub;
                end
            end

            if (s2_ready) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    ans_reg   <= res_next;
                    cy_br_reg <= cy_br_next;
                    ovf_reg   <= ovf_next;
                end
            end

            // Clear wins over the update from an op advancing in the same cycle.
            if (ACC_CLR) begin
                acc_reg <= '0;
            end else if (s1_adv) begin
                acc_reg <= res_next;
            end
        end
    end

    assign OUT_VALID = out_valid_reg;
    assign ANS       = ans_reg;
    assign CY_BR_OUT = cy_br_reg;
    assign OVF       = ovf_reg;
    assign ACC       = acc_reg;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe (WIDTH=8): directed cases plus random
// traffic checked against an integer-arithmetic reference model.
module tb_add_sub_pipe;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   OP;
    logic         ACC_CLR;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] ANS;
    logic         CY_BR_OUT;
    logic         OVF;
    logic [W-1:0] ACC;

    add_sub_pipe #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .ACC_CLR   (ACC_CLR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ANS       (ANS),
        .CY_BR_OUT (CY_BR_OUT),
        .OVF       (OVF),
        .ACC       (ACC)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] ans;
        logic         cy;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] model_acc = '0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the selected operands.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] acc);
        exp_t   r;
        longint x, y, sx, sy, full, s;
        x  = op[1] ? longint'(acc) : longint'(a);
        y  = op[1] ? longint'(a) : longint'(b);
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        if (!op[0]) begin
            full = x + y;
            r.cy = (full > 255);
            s    = sx + sy;
        end else begin
            full = x - y;
            r.cy = (x < y);
            s    = sx - sy;
        end
        r.ans = full[W-1:0];
        r.ovf = (s > 127) || (s < -128);
`ifdef ADD_SUB_PIPE_SAT_EN
        if (r.ovf) r.ans = (s > 0) ? 8'h7F : 8'h80;
`endif
        return r;
    endfunction

    // One clock cycle with the current inputs; records an accepted op.
    task automatic step(output bit got);
        exp_t r;
        @(negedge CLK);
        got = IN_VALID && IN_READY;
        if (got) begin
            r = model(OP, A, B, model_acc);
            exp_q.push_back(r);
        end
        if (ACC_CLR && !RST) model_acc = '0;
        if (got) model_acc = r.ans;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int stalls);
        bit got;
        OP = op; A = a; B = b; IN_VALID = 1'b1;
        stalls = 0;
        got = 1'b0;
        while (!got && stalls < 20) begin
            step(got);
            if (!got) stalls++;
        end
        IN_VALID = 1'b0;
        chk("send_accept", got, 1);
    endtask

    task automatic drain();
        bit got;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(got);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", OUT_VALID, 0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("out ans=%02h cy_br=%0d ovf=%0d acc=%02h", ANS, CY_BR_OUT, OVF, ACC);
                chk("ans", ANS, mon_e.ans);
                chk("cy_br", CY_BR_OUT, mon_e.cy);
                chk("ovf", OVF, mon_e.ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int stalls;
        int n;
        int acc_cnt;

        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1; ACC_CLR = 1'b0;
        A = '0; B = '0; OP = 2'b00;

        // Reset state, with IN_VALID asserted to show IN_READY stays low.
        repeat (2) @(posedge CLK);
        #1;
        IN_VALID = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_ans", ANS, 0);
        chk("rst_acc", ACC, 0);
        IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_in_ready", IN_READY, 1);
        @(posedge CLK);
        #1;

        // ADD overflow and two-cycle latency.
        send(2'b00, 8'h7F, 8'h01, stalls);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!OUT_VALID && n < 10);
        chk("latency", n, 2);
        @(posedge CLK);
        #1;
        drain();

        // Subtractions, including a borrow.
        send(2'b01, 8'hF9, 8'h01, stalls);
        send(2'b01, 8'h00, 8'h01, stalls);
        drain();

        // Accumulator ops: one stall cycle between consecutive ACC ops.
        ACC_CLR = 1'b1;
        step(got);
        ACC_CLR = 1'b0;
        send(2'b10, 8'd5, 8'h00, stalls);
        chk("acc_first_stall", stalls, 0);
        send(2'b10, 8'd3, 8'h00, stalls);
        chk("acc_stall_1", stalls, 1);
        send(2'b11, 8'd10, 8'h00, stalls);
        chk("acc_stall_2", stalls, 1);
        drain();
        chk("acc_final", ACC, 8'hFE);

        // Backpressure: only two ops accepted while the output is stalled.
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        OP = 2'b00;
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            A = W'($urandom); B = W'($urandom);
            step(got);
            if (got) acc_cnt++;
        end
        chk("bp_accepts", acc_cnt, 2);
        chk("bp_in_ready", IN_READY, 0);
        OUT_READY = 1'b1;
        for (int i = 0; i < 20 && acc_cnt < 4; i++) begin
            if (got) begin A = W'($urandom); B = W'($urandom); end
            step(got);
            if (got) acc_cnt++;
        end
        chk("bp_total", acc_cnt, 4);
        drain();

        // Clear coinciding with an ACC op advancing into S2.
        send(2'b10, 8'd7, 8'h00, stalls);
        ACC_CLR = 1'b1;
        step(got);
        ACC_CLR = 1'b0;
        @(negedge CLK);
        chk("clr_acc_zero", ACC, 0);
        @(posedge CLK);
        #1;
        drain();
        chk("clr_acc_hold", ACC, 0);

        // Reset with two ops in flight.
        OUT_READY = 1'b0;
        send(2'b00, 8'h11, 8'h22, stalls);
        send(2'b01, 8'h33, 8'h04, stalls);
        RST = 1'b1;
        step(got);
        step(got);
        exp_q.delete();
        model_acc = '0;
        RST = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(got);
            chk("flush_out_valid", OUT_VALID, 0);
        end
        chk("flush_acc", ACC, 0);

        // Random traffic with random backpressure and clears.
        for (int i = 0; i < 500; i++) begin
            IN_VALID  = ($urandom % 4) != 0;
            OP        = 2'($urandom);
            A         = W'($urandom);
            B         = W'($urandom);
            OUT_READY = ($urandom % 4) != 0;
            ACC_CLR   = OUT_READY && (($urandom % 12) == 0);
            step(got);
        end
        ACC_CLR = 1'b0;
        drain();
        chk("rand_acc", ACC, model_acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
